fp_pow_int: RTL

- Sequential IEEE-754 single-precision integer-power unit: out = inputB ^ inputA.
  - inputB is a float base.
  - inputA is an unsigned integer exponent.
- It is the inverse operation of the combinational root unit (out = inputB ^ (1/inputA)) and sits beside it in the TPU scalar/activation path.
- Uses square-and-multiply with a single shared float multiplier, under a start/done handshake.

---
 rtl/fp_pkg.sv | 35 +++
 rtl/fp_mul.sv | 49 ++++
 rtl/fp_pow_int.sv | 112 +++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: shared single-precision constants, field layout, FSM state type
// and classification helpers for the float power unit and its multiplier.
package fp_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_FW = 8;
  localparam int MANT_W = 23;

  localparam logic [31:0]        FP_ONE  = 32'h3F800000;
  localparam logic [31:0]        FP_QNAN = 32'h7FC00000;
  localparam logic [31:0]        FP_PINF = 32'h7F800000;
  localparam logic signed [9:0]  FP_BIAS = 10'sd127;

  typedef struct packed {
    logic [SIGN_W-1:0] sign;
    logic [EXP_FW-1:0] exp;
    logic [MANT_W-1:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] == '0);
  endfunction

  // Zero exponent field covers denormals too; they are flushed to zero.
  function automatic logic is_zero(input logic [31:0] x);
    return x[30:23] == '0;
  endfunction

endpackage

// File: rtl/fp_mul.sv
// fp_mul: combinational single-precision multiply, truncating rounding,
// denormals flushed to zero, overflow to signed inf, underflow to signed zero.
// Ports:
//   inputA, inputB : IEEE-754 single operands
//   out            : IEEE-754 single product
module fp_mul
  import fp_pkg::*;
(
  input  logic [31:0] inputA,
  input  logic [31:0] inputB,
  output logic [31:0] out
);

  fp32_t a, b;
  assign a = inputA;
  assign b = inputB;

  logic               sgn;
  logic [47:0]        prod;
  logic signed [9:0]  exp_s;
  logic [22:0]        mant;
  logic               unused_ok;

  // Low product bits fall below the kept mantissa and are truncated away.
  assign unused_ok = ^prod[22:0];

  always_comb begin
    sgn   = a.sign ^ b.sign;
    prod  = {1'b1, a.mant} * {1'b1, b.mant};
    // Product of two [1,2) mantissas lies in [1,4): one shift at most.
    exp_s = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - FP_BIAS
          + $signed({9'b0, prod[47]});
    mant  = prod[47] ? prod[46:24] : prod[45:23];
    out   = {sgn, exp_s[7:0], mant};
    if (is_nan(inputA) || is_nan(inputB))
      out = FP_QNAN;
    else if ((is_inf(inputA) && is_zero(inputB)) || (is_zero(inputA) && is_inf(inputB)))
      out = FP_QNAN;
    else if (is_inf(inputA) || is_inf(inputB))
      out = {sgn, FP_PINF[30:0]};
    else if (is_zero(inputA) || is_zero(inputB))
      out = {sgn, 31'b0};
    else if (exp_s > 10'sd254)
      out = {sgn, FP_PINF[30:0]};
    else if (exp_s < 10'sd1)
      out = {sgn, 31'b0};
  end

endmodule

// File: rtl/fp_pow_int.sv
// fp_pow_int: sequential out = inputB ^ inputA (float base, unsigned integer
// exponent) by square-and-multiply over one shared fp_mul.
// Optional macro FP_POW_EARLY_EXIT_EN: abandon the loop as soon as the result
// is known to be NaN.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : request, accepted only while busy=0
//   inputA    : unsigned exponent (EXP_W bits), sampled on accept
//   inputB    : IEEE-754 single base, sampled on accept
//   busy      : high from accept through the done cycle
//   done      : one-cycle pulse, out valid then and held afterwards
//   out       : IEEE-754 single result
module fp_pow_int
  import fp_pkg::*;
#(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [EXP_W-1:0] inputA,
  input  logic [31:0]      inputB,
  output logic             busy,
  output logic             done,
  output logic [31:0]      out
);

  state_t           state_q, state_d;
  logic [31:0]      acc, acc_d;
  logic [31:0]      sq, sq_d;
  logic [EXP_W-1:0] e, e_d;
  logic [31:0]      out_q, out_d;
  logic [31:0]      mul_a, mul_out;
  logic             early;

  // A set low bit multiplies into acc; otherwise square the running base.
  assign mul_a = e[0] ? acc : sq;

  fp_mul u_mul (
    .inputA (mul_a),
    .inputB (sq),
    .out    (mul_out)
  );

`ifdef FP_POW_EARLY_EXIT_EN
  // NaN in acc is sticky; NaN in sq reaches acc once any exponent bit is left.
  assign early = is_nan(acc) || (is_nan(sq) && (e != '0));
`else
  assign early = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc;
    sq_d    = sq;
    e_d     = e;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = FP_ONE;
          sq_d  = inputB;
          e_d   = inputA;
          if (inputA == '0) begin
            state_d = DONE;
            out_d   = FP_ONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (early) begin
          state_d = DONE;
          out_d   = FP_QNAN;
        end else if (e == '0) begin
          state_d = DONE;
          out_d   = acc;
        end else if (e[0]) begin
          acc_d  = mul_out;
          e_d[0] = 1'b0;
        end else begin
          sq_d = mul_out;
          e_d  = e >> 1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc     <= '0;
      sq      <= '0;
      e       <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc     <= acc_d;
      sq      <= sq_d;
      e       <= e_d;
      out_q   <= out_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign out  = out_q;

endmodule
